sand_mem_editor: RTL and testbench
==================================

# sand_mem_editor

Parametrised pushbutton memory editor that drives a synchronous single-port RAM (one-cycle read latency, old-data read-during-write). It debounces four active-low keys, steps a cursor address, and performs read-modify-write increments/decrements of the addressed word with a sequenced write pulse. It sits between the board keys and the RAM; `a` and `dout` also feed the hex7seg display path.

## Interface
- `ADDR_W`, 4, address width; depth is 2^ADDR_W.
- `DATA_W`, 8, data word width.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to change a debounced key state; minimum 1.
- `REPEAT_DELAY`, 25_000_000, cycles a key is held before the first auto-repeat; used only with repeat compiled in.
- `REPEAT_PERIOD`, 5_000_000, cycles between subsequent auto-repeats; minimum 4; used only with repeat compiled in.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `KEY`  in  4  raw pushbuttons, active-low, asynchronous. KEY[3] is address+1, KEY[2] is address−1, KEY[1] is data+1, KEY[0] is data−1.
- `dout`  in  DATA_W  RAM read data, valid one cycle after `a` is stable.
- `a`  out  ADDR_W  RAM address/cursor.
- `din`  out  DATA_W  RAM write data.
- `we`  out  1  RAM write enable, one-cycle pulse.
- `busy`  out  1  read-modify-write in progress.
- `pressed`  out  4  debounced key levels, active-high.

## Operation
- **Input synchronisation.** Each KEY bit passes through a 2-flop synchroniser. The synchroniser flops reset to 1 (released).
- **Debounce.** Each key has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever the synchronised level equals the current debounced state.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
- **Command generation.**
  - A command pulse fires on the cycle a debounced state goes from released to pressed, but only if exactly one key is pressed afterwards.
  - When two or more keys are pressed, no command fires and any repeat timer is cleared.
- **FSM states:** IDLE, READ, WRITE, SETTLE.
  - IDLE, address command: `a` ← `a`±1, modulo 2^ADDR_W (wraps 0↔max). The FSM stays in IDLE.
  - IDLE, data command: latch the direction and go to READ.
  - READ → WRITE unconditionally.
  - WRITE: `din` ← `dout`±1, modulo 2^DATA_W, with `we`=1 for this cycle only; then go to SETTLE.
  - SETTLE → IDLE. This state guarantees `dout` reflects the written value before the next operation.
- **Busy handling.** `busy`=1 in READ, WRITE and SETTLE. `a` is frozen while busy. Commands arriving while busy are dropped, not queued.
- **Reset values.** `a`=0, `din`=0, `we`=0, `busy`=0, `pressed`=0. Debounce counters are 0, the FSM is in IDLE and repeat timers are 0. Reset asserted in READ, WRITE or SETTLE aborts the operation: `we` is 0 on the cycle after reset is sampled.

## Timing
- **KEY to `pressed`.** A clean KEY falling edge appears on `pressed` 2 + DEBOUNCE_CYCLES cycles later. The command pulse is in the same cycle as the `pressed` rise.
- **Address command.** Command in cycle N → new `a` visible in cycle N+1.
- **Data command.** Command in cycle N:
  - READ in N+1.
  - WRITE in N+2, where `we`=1 and `din` holds the modified value (registered, valid while `we`=1).
  - SETTLE in N+3.
  - IDLE in N+4; the next command can be accepted in N+4.
- **Back-to-back commands.** The minimum spacing between accepted data commands is 4 cycles.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES never changes `pressed`.

## Configuration
- `SAND_EDIT_REPEAT_EN` defined:
  - While exactly one key stays pressed, a repeat counter starts at the press command.
  - A repeat command fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - A repeat landing while busy is dropped; the timer keeps running.
  - Release, or a second key being pressed, clears the counter.
- `SAND_EDIT_REPEAT_EN` undefined:
  - Exactly one command per press. A key must release (debounced) before it can issue again.
  - The repeat logic and parameters are unused.

## Test plan
Bench parameters: ADDR_W=4, DATA_W=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=6. The RAM model is preloaded with mem[i]=i.
1. Reset, then press KEY=4'b0111 held clean → `pressed`=4'b1000 exactly 6 cycles after the edge, and `a` goes 0→1 the next cycle; a 3-cycle glitch on KEY[3] → no change.
2. `a`=0, press KEY[2] → `a`=4'hF (wrap); `a`=4'hF, press KEY[3] → `a`=0.
3. `a`=3, press KEY[1] → `we`=1 for exactly one cycle, 2 cycles after the command, with `din`=8'h04, `busy`=1 for 3 cycles; `dout`=8'h04 once IDLE. Then at an address holding 8'h00, press KEY[0] → `din`=8'hFF.
4. Press KEY[3] and KEY[1] simultaneously → no `a` change and no `we` pulse. Assert `reset` in the WRITE cycle → `we`=0 the next cycle, `a`=0, `busy`=0.
5. With `SAND_EDIT_REPEAT_EN`, hold KEY[1] for 40 cycles past debounce → `we` pulses at command+2, +22, +28, +34 relative to the press command; `din` reads 1, 2, 3, 4 above the original. Without the macro → a single pulse only.

Source files
------------

// File: rtl/sand_mem_editor.sv
// sand_mem_editor: debounced four-key RAM editor (cursor step, read-modify-write +/-1). Ports: clk, reset (sync, active-high), KEY[3:0] (raw, active-low), dout (RAM read data), a (cursor/RAM address), din (RAM write data), we (one-cycle write pulse), busy (RMW in flight), pressed[3:0] (debounced, active-high). Optional auto-repeat: define SAND_EDIT_REPEAT_EN.
module sand_mem_editor #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        KEY,
  input  logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] din,
  output logic              we,
  output logic              busy,
  output logic [3:0]        pressed
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, SETTLE} state_t;
  logic [3:0] r_sync1, r_sync2, r_pressed, r_prev;
  logic [DW-1:0] r_cnt [4];
  logic [3:0] w_lvl, w_rise, w_rep, w_cmd;
  logic w_one;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_din;
  logic r_dir;
  assign w_lvl = ~r_sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pressed <= '0;
      r_prev <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
      r_prev <= r_pressed;
      for (int i = 0; i < 4; i++)
        if (w_lvl[i] == r_pressed[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt[i] <= '0;
          r_pressed[i] <= ~r_pressed[i];
        end else r_cnt[i] <= r_cnt[i] + DW'(1);
    end
  end
  assign w_rise = r_pressed & ~r_prev;
  assign w_one = $onehot(r_pressed);
`ifdef SAND_EDIT_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  // Down-counter: 0 = idle, fires on 1, then reloads with the period.
  logic [RW-1:0] r_rep;
  always_ff @(posedge clk)
    if (reset || !w_one) r_rep <= '0;
    else if (|w_rise) r_rep <= RW'(REPEAT_DELAY);
    else if (r_rep == RW'(1)) r_rep <= RW'(REPEAT_PERIOD);
    else if (r_rep != '0) r_rep <= r_rep - RW'(1);
  assign w_rep = (w_one && r_rep == RW'(1)) ? r_pressed : 4'b0;
`else
  assign w_rep = 4'b0;
`endif
  assign w_cmd = w_one ? (w_rise | w_rep) : 4'b0;
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb
    w_next = (r_state == IDLE) ? ((|w_cmd[1:0]) ? READ : IDLE) :
             (r_state == READ) ? WRITE :
             (r_state == WRITE) ? SETTLE : IDLE;
  always_comb begin
    busy = r_state != IDLE;
    we = r_state == WRITE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_din <= '0;
      r_dir <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_a <= w_cmd[3] ? r_a + ADDR_W'(1) : w_cmd[2] ? r_a - ADDR_W'(1) : r_a;
        if (|w_cmd[1:0]) r_dir <= w_cmd[1];
      end
      // dout in READ holds the word at the frozen cursor.
      if (r_state == READ) r_din <= r_dir ? dout + DATA_W'(1) : dout - DATA_W'(1);
    end
  end
  assign a = r_a;
  assign din = r_din;
  assign pressed = r_pressed;
endmodule

// File: tb/tb_sand_mem_editor.sv
// tb_sand_mem_editor: directed self-checking bench for sand_mem_editor with a RAM model.
module tb_sand_mem_editor;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] KEY;
  logic [7:0] dout;
  logic [3:0] a;
  logic [7:0] din;
  logic we, busy;
  logic [3:0] pressed;
  logic [7:0] mem [16];
  int vectors = 0;
  int miscompares = 0;
  int we_cnt, np;
  int pt [8];
  logic [7:0] pd [8];
  logic seen;
  sand_mem_editor #(.ADDR_W(4), .DATA_W(8), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(6)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .dout(dout), .a(a), .din(din), .we(we), .busy(busy), .pressed(pressed)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 16; i++) mem[i] = 8'(i);
  always @(posedge clk) begin
    if (we) mem[a] <= din;
    dout <= mem[a];
  end
  task tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task press_key(input logic [3:0] k);
    KEY = k;
    tick(7);
    KEY = 4'hF;
    tick(8);
  endtask
  initial begin
    int et [4];
    logic [7:0] ed [4];
    int ne;
    reset = 1'b1;
    KEY = 4'hF;
    tick(3);
    reset = 1'b0;
    chk("rst_a", a, 0);
    chk("rst_din", din, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pressed", pressed, 0);
    KEY = 4'b0111;
    tick(5);
    chk("press_lat5", pressed, 4'b0000);
    tick(1);
    chk("press_lat6", pressed, 4'b1000);
    chk("a_cmd_cycle", a, 0);
    tick(1);
    chk("a_inc", a, 1);
    KEY = 4'hF;
    tick(8);
    chk("release", pressed, 0);
    KEY = 4'b0111;
    tick(3);
    KEY = 4'hF;
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      if (pressed != 4'b0) seen = 1'b1;
    end
    chk("glitch_pressed", seen, 0);
    chk("glitch_a", a, 1);
    press_key(4'b1011);
    chk("a_dec", a, 0);
    press_key(4'b1011);
    chk("a_wrap_down", a, 4'hF);
    press_key(4'b0111);
    chk("a_wrap_up", a, 0);
    repeat (3) press_key(4'b0111);
    chk("a_at3", a, 3);
    KEY = 4'b1101;
    tick(6);
    chk("rmw_n_busy", busy, 0);
    tick(1);
    chk("rmw_n1_busy", busy, 1);
    chk("rmw_n1_we", we, 0);
    tick(1);
    chk("rmw_n2_we", we, 1);
    chk("rmw_n2_din", din, 8'h04);
    chk("rmw_n2_busy", busy, 1);
    tick(1);
    chk("rmw_n3_we", we, 0);
    chk("rmw_n3_busy", busy, 1);
    tick(1);
    chk("rmw_n4_busy", busy, 0);
    chk("rmw_n4_dout", dout, 8'h04);
    KEY = 4'hF;
    tick(8);
    repeat (3) press_key(4'b1011);
    chk("a_at0", a, 0);
    KEY = 4'b1110;
    tick(8);
    chk("dec_we", we, 1);
    chk("dec_din", din, 8'hFF);
    KEY = 4'hF;
    tick(10);
    KEY = 4'b0101;
    we_cnt = 0;
    repeat (12) begin
      tick(1);
      we_cnt += int'(we);
    end
    chk("dual_pressed", pressed, 4'b1010);
    chk("dual_a", a, 0);
    chk("dual_we", we_cnt, 0);
    KEY = 4'hF;
    tick(8);
    press_key(4'b0111);
    press_key(4'b0111);
    chk("a_at2", a, 2);
    KEY = 4'b1101;
    tick(8);
    chk("abort_we_pre", we, 1);
    reset = 1'b1;
    KEY = 4'hF;
    tick(1);
    chk("abort_we", we, 0);
    chk("abort_a", a, 0);
    chk("abort_busy", busy, 0);
    chk("abort_din", din, 0);
    reset = 1'b0;
    tick(10);
    chk("post_abort_a", a, 0);
    repeat (5) press_key(4'b0111);
    chk("a_at5", a, 5);
`ifdef SAND_EDIT_REPEAT_EN
    ne = 4;
    et = '{2, 22, 28, 34};
    ed = '{8'h06, 8'h07, 8'h08, 8'h09};
`else
    ne = 1;
    et = '{2, 0, 0, 0};
    ed = '{8'h06, 8'h00, 8'h00, 8'h00};
`endif
    KEY = 4'b1101;
    tick(6);
    chk("rep_cmd_pressed", pressed, 4'b0010);
    np = 0;
    for (int t = 1; t <= 37; t++) begin
      tick(1);
      if (we && np < 8) begin
        pt[np] = t;
        pd[np] = din;
        np++;
      end else if (we) np++;
    end
    KEY = 4'hF;
    chk("rep_count", np, ne);
    for (int i = 0; i < ne && i < np; i++) begin
      chk($sformatf("rep_time%0d", i), pt[i], et[i]);
      chk($sformatf("rep_din%0d", i), pd[i], ed[i]);
    end
    tick(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
